// File: rtl/pulse_seq_pkg.sv
// pulse_seq_pkg: shared state encoding, default idle pattern and table entry layout
package pulse_seq_pkg;
  typedef enum logic {S_IDLE, S_RUN} state_t;
  localparam int DEF_DUR_W = 22;
  localparam int DEF_OUT_W = 8;
  localparam logic [DEF_OUT_W-1:0] DEF_IDLE_PATTERN = 8'b1000_0001;
  typedef struct packed {
    logic [DEF_DUR_W-1:0] dur;
    logic [DEF_OUT_W-1:0] pattern;
    logic                 trig;
  } step_t;
endpackage

// File: rtl/pulse_step_table.sv
// pulse_step_table: STEPS-entry step register file, sync write, comb read, sync clear
module pulse_step_table #(
  parameter int STEPS = 16,
  parameter int DUR_W = 22,
  parameter int OUT_W = 8,
  parameter logic [OUT_W-1:0] IDLE_PATTERN = '0,
  localparam int AW = $clog2(STEPS)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [DUR_W-1:0] wdur_i,
  input  logic [OUT_W-1:0] wpat_i,
  input  logic             wtrig_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [DUR_W-1:0] rdur_o,
  output logic [OUT_W-1:0] rpat_o,
  output logic             rtrig_o
);
  logic [DUR_W-1:0] dur_q [STEPS];
  logic [OUT_W-1:0] pat_q [STEPS];
  logic [STEPS-1:0] trig_q;
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < STEPS; i++) begin
        dur_q[i] <= '0;
        pat_q[i] <= IDLE_PATTERN;
      end
      trig_q <= '0;
    end else if (we_i) begin
      dur_q[waddr_i]  <= wdur_i;
      pat_q[waddr_i]  <= wpat_i;
      trig_q[waddr_i] <= wtrig_i;
    end
  end
  assign rdur_o  = dur_q[raddr_i];
  assign rpat_o  = pat_q[raddr_i];
  assign rtrig_o = trig_q[raddr_i];
endmodule

// File: rtl/pulse_sequencer.sv
// pulse_sequencer: steps a programmable (duration, pattern, trigger) table with
// finite/infinite looping, start/stop control and registered pulse outputs
module pulse_sequencer
  import pulse_seq_pkg::*;
#(
  parameter int STEPS  = 16,
  parameter int DUR_W  = 22,
  parameter int OUT_W  = 8,
  parameter int LOOP_W = 16,
  parameter logic [OUT_W-1:0] IDLE_PATTERN = OUT_W'(DEF_IDLE_PATTERN),
  localparam int AW = $clog2(STEPS)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [DUR_W-1:0]  cfg_dur,
  input  logic [OUT_W-1:0]  cfg_pattern,
  input  logic              cfg_trig,
  input  logic [AW-1:0]     last_step,
  input  logic [LOOP_W-1:0] loop_count,
  input  logic              start,
  input  logic              stop,
  output logic [OUT_W-1:0]  signal_out,
  output logic              trigger,
  output logic              busy,
  output logic              done,
  output logic [AW-1:0]     step_index
);
  state_t            state_q, state_d;
  logic [AW-1:0]     step_q, step_d, last_q, last_d, nxt;
  logic [DUR_W-1:0]  cnt_q, cnt_d, rd_dur;
  logic [LOOP_W-1:0] loops_q, loops_d;
  logic [OUT_W-1:0]  sig_q, sig_d, rd_pat;
  logic              trig_q, trig_d, done_q, done_d, rd_trig, entry;
  pulse_step_table #(
    .STEPS(STEPS), .DUR_W(DUR_W), .OUT_W(OUT_W), .IDLE_PATTERN(IDLE_PATTERN)
  ) u_table (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .we_i   (cfg_we),
    .waddr_i(cfg_addr),
    .wdur_i (cfg_dur),
    .wpat_i (cfg_pattern),
    .wtrig_i(cfg_trig),
    .raddr_i(nxt),
    .rdur_o (rd_dur),
    .rpat_o (rd_pat),
    .rtrig_o(rd_trig)
  );
  assign nxt = (state_q == S_RUN && step_q != last_q) ? step_q + 1'b1 : '0;
  // loops_q == 0 only ever means "forever": a finite count ends at 1 instead of decrementing
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    trig_d  = 1'b0;
    done_d  = 1'b0;
    last_d  = last_q;
    loops_d = loops_q;
    entry   = 1'b0;
    if (state_q == S_IDLE) begin
      if (start && !stop) begin
        state_d = S_RUN;
        last_d  = last_step;
        loops_d = loop_count;
        entry   = 1'b1;
      end
    end else if (stop) begin
      state_d = S_IDLE;
      step_d  = '0;
      sig_d   = IDLE_PATTERN;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end else if (step_q != last_q || loops_q == '0) begin
      entry = 1'b1;
    end else if (loops_q > LOOP_W'(1)) begin
      loops_d = loops_q - 1'b1;
      entry   = 1'b1;
    end else begin
      state_d = S_IDLE;
      step_d  = '0;
      sig_d   = IDLE_PATTERN;
      done_d  = 1'b1;
    end
    if (entry) begin
      step_d = nxt;
      cnt_d  = rd_dur;
      sig_d  = rd_pat;
      trig_d = rd_trig;
    end
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      cnt_q   <= '0;
      sig_q   <= IDLE_PATTERN;
      trig_q  <= 1'b0;
      done_q  <= 1'b0;
      last_q  <= '0;
      loops_q <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
      trig_q  <= trig_d;
      done_q  <= done_d;
      last_q  <= last_d;
      loops_q <= loops_d;
    end
  end
  assign signal_out = sig_q;
  assign trigger    = trig_q;
  assign busy       = (state_q == S_RUN);
  assign done       = done_q;
  assign step_index = step_q;
endmodule
